// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multi-cycle RV32I datapath (shared ALU, unified
// instruction/data memory, architectural registers PC, OldPC, IR, MDR, A, B,
// ALUOut). Sequences fetch / decode / execute / memory / writeback for each
// instruction by driving datapath mux selects and write enables. Conditional
// branches are resolved here from func3 and the ALU zero/negative flags.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-low reset
//   op         in   7  IR[6:0]
//   func3      in   3  IR[14:12]
//   zero       in   1  ALU result == 0
//   negative   in   1  ALU result MSB (signed less-than after subtract)
//   PCWrite    out  1  PC <= Result
//   AdrSrc     out  1  memory address: 0 = PC, 1 = Result
//   MemWrite   out  1  memory write enable
//   IRWrite    out  1  IR and OldPC load enable
//   RegWrite   out  1  register file write enable
//   ResultSrc  out  2  00 ALUOut, 01 MDR, 10 ALUResult, 11 immediate
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 A
//   ALUSrcB    out  2  00 B, 01 immediate, 10 constant 4
//   ALUOp      out  2  00 add, 01 subtract, 10 decode from func3/func7
//   ImmSrc     out  3  000 I, 001 S, 010 B, 011 J, 100 U
//
// Outputs are a Moore decode of the state, except PCWrite in BRANCH (depends
// on func3/zero/negative) and ImmSrc (decoded from op only). All outputs are
// forced to 0 while rst is low, so a mid-instruction reset drops every enable
// without waiting for a clock edge.
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       negative,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc
);

  // RV32I opcode constants
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   taken_s;

  // Branch condition from func3 and the flags of the A - B subtract.
  // BGE is "not less-than", which includes the equal case.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       z,
                                        input logic       n);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = ~z;
      3'b100:  t = n;
      3'b101:  t = z | ~n;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // State register with asynchronous active-low reset to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE:  next_state_s = S_MEMADR;
          OP_RTYPE:  next_state_s = S_EXECR;
          OP_ITYPE:  next_state_s = S_EXECI;
          OP_BRANCH: next_state_s = S_BRANCH;
          OP_JAL:    next_state_s = S_JAL;
          OP_JALR:   next_state_s = S_JALR;
          OP_LUI:    next_state_s = S_LUI;
          // illegal opcode retires as a no-op
          default:   next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LOAD) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD:  next_state_s = S_MEMWB;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = S_FETCH;
      S_EXECR:    next_state_s = S_ALUWB;
      S_EXECI:    next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      S_JAL:      next_state_s = S_ALUWB;
      S_JALR:     next_state_s = S_JALRPC;
      S_JALRPC:   next_state_s = S_ALUWB;
      S_LUI:      next_state_s = S_FETCH;
      default:    next_state_s = S_FETCH;
    endcase
  end

  assign taken_s = branch_taken(func3, zero, negative);

  // Per-state control decode; everything is held at 0 while in reset
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    if (rst) begin
      case (state_r)
        S_FETCH: begin
          // IR <= mem[PC]; PC <= PC + 4 straight from the ALU result
          AdrSrc    = 1'b0;
          IRWrite   = 1'b1;
          ALUSrcA   = 2'b00;
          ALUSrcB   = 2'b10;
          ALUOp     = 2'b00;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_DECODE: begin
          // ALUOut <= OldPC + imm, the branch / jal target
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b00;
        end
        S_MEMADR, S_JALR: begin
          // ALUOut <= A + imm (load/store address or jalr target)
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b00;
        end
        S_MEMREAD: begin
          AdrSrc    = 1'b1;
          ResultSrc = 2'b00;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc    = 1'b1;
          ResultSrc = 2'b00;
          MemWrite  = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b00;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          ResultSrc = 2'b00;
          RegWrite  = 1'b1;
        end
        S_BRANCH: begin
          // compare A - B; target already sits in ALUOut from DECODE
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b00;
          ALUOp     = 2'b01;
          ResultSrc = 2'b00;
          PCWrite   = taken_s;
        end
        S_JAL, S_JALRPC: begin
          // PC <= target held in ALUOut while ALUOut <= OldPC + 4 (link)
          ResultSrc = 2'b00;
          PCWrite   = 1'b1;
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ALUOp     = 2'b00;
        end
        S_LUI: begin
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end else begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
    end
  end

  // Immediate format select from the opcode alone
  always_comb begin
    ImmSrc = 3'b000;
    if (rst) begin
      case (op)
        OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
        OP_STORE:                   ImmSrc = 3'b001;
        OP_BRANCH:                  ImmSrc = 3'b010;
        OP_JAL:                     ImmSrc = 3'b011;
        OP_LUI:                     ImmSrc = 3'b100;
        default:                    ImmSrc = 3'b000;
      endcase
    end else begin
      ImmSrc = 3'b000;
    end
  end

endmodule
